// File: rtl/i2s_rx.sv
// i2s_rx - I2S slave receiver.
//
// Deserialises a stereo I2S stream (SCLK/LRCLK/SD driven by an external
// codec) into left/right sample pairs presented on a valid/ready port.
// Everything runs on CLK; the serial pins are oversampled through
// SYNC_STAGES-deep synchronisers, so SCLK must not exceed CLK/4.
//
// Optional build macro:
//   I2S_RX_LEFT_JUSTIFIED_EN - left-justified framing (no one-bit delay,
//                              LRCLK high = left). Undefined: standard I2S.
//
// Ports:
//   CLK, RST_N          system clock, async active-low reset
//   ENABLE              receiver enable; low drops back to SYNC
//   I2S_SCLK/LRCLK/SD   serial inputs from the codec
//   OUT_L, OUT_R        published sample pair (left-aligned to WIDTH)
//   OUT_VALID/OUT_READY pair handshake
//   OVERRUN, OVR_CLR    sticky "unread pair overwritten" flag and its clear
//   LOCKED              receiver is aligned to the frame
module i2s_rx #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             ENABLE,
    input  logic             I2S_SCLK,
    input  logic             I2S_LRCLK,
    input  logic             I2S_SD,
    output logic [WIDTH-1:0] OUT_L,
    output logic [WIDTH-1:0] OUT_R,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic             OVERRUN,
    input  logic             OVR_CLR,
    output logic             LOCKED
);

    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  WMAX = CW'(WIDTH);
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
    localparam logic LEFT_LVL = 1'b1;
`else
    localparam logic LEFT_LVL = 1'b0;
`endif

    typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync, lr_sync, sd_sync;
    logic                   sclk_last;
    logic                   sclk_rise;
    logic                   smp_vld, smp_lr, smp_sd;
    logic                   lr_prev, prev_ok;
    logic                   boundary;
    state_t                 state;
    logic [WIDTH-1:0]       sh, sh_nxt, pend_l, word_c;
    logic [CW-1:0]          cnt, cnt_nxt;

    // Left-align a partially received word; unreceived LSBs read as zero.
    function automatic logic [WIDTH-1:0] align(input logic [WIDTH-1:0] s,
                                               input logic [CW-1:0]    n);
        return (n == '0) ? '0 : (s << (WIDTH - int'(n)));
    endfunction

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sclk_sync <= '0;
            lr_sync   <= '0;
            sd_sync   <= '0;
            sclk_last <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], I2S_SCLK};
            lr_sync   <= {lr_sync[SYNC_STAGES-2:0],   I2S_LRCLK};
            sd_sync   <= {sd_sync[SYNC_STAGES-2:0],   I2S_SD};
            sclk_last <= sclk_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_last;

    // Register the sampled bit once more so the frame logic sees a clean
    // one-cycle strobe with LRCLK/SD captured at the same instant.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            smp_vld <= 1'b0;
            smp_lr  <= 1'b0;
            smp_sd  <= 1'b0;
        end else begin
            smp_vld <= sclk_rise;
            if (sclk_rise) begin
                smp_lr <= lr_sync[SYNC_STAGES-1];
                smp_sd <= sd_sync[SYNC_STAGES-1];
            end
        end
    end

    // The first edge after reset has no predecessor, so it can never be a
    // boundary; this keeps a stream joined mid-word from locking early.
    assign boundary = smp_vld && prev_ok && (smp_lr != lr_prev);

    always_comb begin
        sh_nxt  = sh;
        cnt_nxt = cnt;
        if (cnt < WMAX) begin
            sh_nxt  = {sh[WIDTH-2:0], smp_sd};
            cnt_nxt = cnt + CW'(1);
        end
    end

`ifdef I2S_RX_LEFT_JUSTIFIED_EN
    assign word_c = align(sh, cnt);
`else
    // The bit on the boundary edge is still the LSB of the outgoing word.
    assign word_c = align(sh_nxt, cnt_nxt);
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            lr_prev   <= 1'b0;
            prev_ok   <= 1'b0;
            state     <= SYNC;
            LOCKED    <= 1'b0;
            sh        <= '0;
            cnt       <= '0;
            pend_l    <= '0;
            OUT_L     <= '0;
            OUT_R     <= '0;
            OUT_VALID <= 1'b0;
            OVERRUN   <= 1'b0;
        end else begin
            if (OUT_VALID && OUT_READY)
                OUT_VALID <= 1'b0;
            if (OVR_CLR)
                OVERRUN <= 1'b0;

            // LRCLK history is tracked even while disabled so the first
            // boundary after re-enable is a genuine transition.
            if (smp_vld) begin
                lr_prev <= smp_lr;
                prev_ok <= 1'b1;
            end

            if (!ENABLE) begin
                state  <= SYNC;
                LOCKED <= 1'b0;
                sh     <= '0;
                cnt    <= '0;
            end else if (boundary) begin
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
                sh  <= {{(WIDTH-1){1'b0}}, smp_sd};
                cnt <= CW'(1);
`else
                sh  <= '0;
                cnt <= '0;
`endif
                case (state)
                    SYNC: begin
                        if (smp_lr == LEFT_LVL) begin
                            state  <= LEFT;
                            LOCKED <= 1'b1;
                        end
                    end
                    LEFT: begin
                        pend_l <= word_c;
                        state  <= RIGHT;
                    end
                    RIGHT: begin
                        OUT_L     <= pend_l;
                        OUT_R     <= word_c;
                        OUT_VALID <= 1'b1;
                        // A same-cycle READY accepts the old pair instead.
                        if (OUT_VALID && !OUT_READY)
                            OVERRUN <= 1'b1;
                        state <= LEFT;
                    end
                    default: begin
                        state  <= SYNC;
                        LOCKED <= 1'b0;
                    end
                endcase
            end else if (smp_vld) begin
                sh  <= sh_nxt;
                cnt <= cnt_nxt;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx - directed bench for i2s_rx (WIDTH=16, SYNC_STAGES=2).
// Drives SCLK at CLK/8 with data changing while SCLK is low, and checks
// published pairs, handshake, overrun, enable, reset and latency.
module tb_i2s_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        i2s_sclk = 1'b0;
    logic        i2s_lrclk = 1'b0;
    logic        i2s_sd = 1'b0;
    logic [15:0] out_l, out_r;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        overrun;
    logic        ovr_clr = 1'b0;
    logic        locked;

    int vectors = 0;
    int errors  = 0;

`ifdef I2S_RX_LEFT_JUSTIFIED_EN
    localparam logic LL = 1'b1;
`else
    localparam logic LL = 1'b0;
`endif
    localparam logic RL = ~LL;

    logic carry   = 1'b0;   // delayed bit for standard I2S framing
    bit   started = 1'b0;   // first bit of the next frame already sent

    i2s_rx #(.WIDTH(16), .SYNC_STAGES(2)) dut (
        .CLK(clk), .RST_N(rst_n), .ENABLE(enable),
        .I2S_SCLK(i2s_sclk), .I2S_LRCLK(i2s_lrclk), .I2S_SD(i2s_sd),
        .OUT_L(out_l), .OUT_R(out_r), .OUT_VALID(out_valid),
        .OUT_READY(out_ready), .OVERRUN(overrun), .OVR_CLR(ovr_clr),
        .LOCKED(locked)
    );

    always #5 clk = ~clk;

    // One SCLK period; entered and left on a CLK falling edge.
    task automatic send_bit(input logic lr, input logic d);
        i2s_lrclk = lr;
        i2s_sd    = d;
        i2s_sclk  = 1'b0;
        repeat (4) @(negedge clk);
        i2s_sclk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // One stereo frame: words of nbits, MSB first, in slots of slot bits.
    task automatic send_frame(input logic [15:0] l, input logic [15:0] r,
                              input int nbits, input int slot);
        for (int i = 0; i < 2 * slot; i++) begin
            int          ch, pos;
            logic [15:0] w;
            logic        b, lr;
            ch  = i / slot;
            pos = i % slot;
            w   = (ch == 0) ? l : r;
            b   = (pos < nbits) ? w[nbits-1-pos] : 1'b0;
            lr  = (ch == 0) ? LL : RL;
            if (i == 0 && started) begin
                carry = b;
            end else begin
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
                send_bit(lr, b);
`else
                send_bit(lr, carry);
                carry = b;
`endif
            end
        end
        started = 1'b0;
    endtask

    // Sends the first (boundary) bit of the next frame, which publishes the
    // pair just sent. lat = CLK edges from first SCLK-high sample to a 0->1
    // OUT_VALID (-1 if none). Optionally pulses READY on the publish edge.
    task automatic flush(input logic nmsb, input bit rdy_pub, output int lat);
        logic v0;
        v0        = out_valid;
        i2s_lrclk = LL;
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
        i2s_sd = nmsb;
`else
        i2s_sd = carry;
`endif
        carry    = nmsb;
        started  = 1'b1;
        i2s_sclk = 1'b0;
        repeat (4) @(negedge clk);
        i2s_sclk = 1'b1;
        lat = -1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (rdy_pub && k == 3) out_ready = 1'b1;
            if (rdy_pub && k == 4) out_ready = 1'b0;
            if (lat < 0 && !v0 && out_valid) lat = k;
        end
        @(negedge clk);
        i2s_sclk = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++; if (out_l !== 16'h0) begin errors++; $display("FAIL reset_out_l: got %h want 0000", out_l); end
        vectors++; if (out_r !== 16'h0) begin errors++; $display("FAIL reset_out_r: got %h want 0000", out_r); end
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        vectors++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        vectors++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", locked); end
        rst_n  = 1'b1;
        enable = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat;
        send_frame(16'h0000, 16'h0000, 16, 32);   // lock frame
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_no_early_valid: got %b want 0", out_valid); end
        send_frame(16'h1234, 16'hABCD, 16, 32);
        flush(1'b1, 1'b0, lat);                   // next word 0xABC, MSB 1
        vectors++; if (lat !== 4) begin errors++; $display("FAIL basic_latency: got %0d want 4", lat); end
        vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", out_valid); end
        vectors++; if (out_l !== 16'h1234) begin errors++; $display("FAIL basic_out_l: got %h want 1234", out_l); end
        vectors++; if (out_r !== 16'hABCD) begin errors++; $display("FAIL basic_out_r: got %h want abcd", out_r); end
        vectors++; if (locked !== 1'b1) begin errors++; $display("FAIL basic_locked: got %b want 1", locked); end
        vectors++; if (overrun !== 1'b0) begin errors++; $display("FAIL basic_overrun: got %b want 0", overrun); end
        consume();
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_accept: got %b want 0", out_valid); end
    endtask

    task automatic test_short_word();
        int lat;
        send_frame(16'h0ABC, 16'h0123, 12, 12);
        flush(1'b0, 1'b0, lat);
        vectors++; if (out_l !== 16'hABC0) begin errors++; $display("FAIL short_out_l: got %h want abc0", out_l); end
        vectors++; if (out_r !== 16'h1230) begin errors++; $display("FAIL short_out_r: got %h want 1230", out_r); end
        consume();
    endtask

    task automatic test_overrun();
        int lat;
        send_frame(16'h0001, 16'h0002, 16, 16);
        send_frame(16'h0003, 16'h0004, 16, 16);
        vectors++; if (out_l !== 16'h0001 || out_r !== 16'h0002) begin errors++; $display("FAIL ovr_first_pair: got %h/%h want 0001/0002", out_l, out_r); end
        vectors++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_first_flag: got %b want 0", overrun); end
        flush(1'b0, 1'b0, lat);
        vectors++; if (out_l !== 16'h0003 || out_r !== 16'h0004) begin errors++; $display("FAIL ovr_pair: got %h/%h want 0003/0004", out_l, out_r); end
        vectors++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b want 1", overrun); end
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        vectors++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", overrun); end
        vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid_kept: got %b want 1", out_valid); end
    endtask

    task automatic test_ready_on_publish();
        int lat;
        send_frame(16'h0005, 16'h0006, 16, 16);
        flush(1'b0, 1'b1, lat);
        vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rop_valid: got %b want 1", out_valid); end
        vectors++; if (out_l !== 16'h0005 || out_r !== 16'h0006) begin errors++; $display("FAIL rop_pair: got %h/%h want 0005/0006", out_l, out_r); end
        vectors++; if (overrun !== 1'b0) begin errors++; $display("FAIL rop_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_enable();
        enable = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (locked !== 1'b0) begin errors++; $display("FAIL en_locked: got %b want 0", locked); end
        vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL en_valid_kept: got %b want 1", out_valid); end
        vectors++; if (out_l !== 16'h0005 || out_r !== 16'h0006) begin errors++; $display("FAIL en_pair_kept: got %h/%h want 0005/0006", out_l, out_r); end
        enable = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        int lat;
        started = 1'b0;
        carry   = 1'b0;
        for (int i = 0; i < 4; i++) send_bit(RL, 1'b1);   // tail of a right word
        for (int i = 0; i < 6; i++) send_bit(LL, 1'b1);   // partial left word
        i2s_sclk = 1'b0;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (out_l !== 16'h0 || out_r !== 16'h0) begin errors++; $display("FAIL mid_reset_pair: got %h/%h want 0000/0000", out_l, out_r); end
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b want 0", out_valid); end
        vectors++; if (overrun !== 1'b0 || locked !== 1'b0) begin errors++; $display("FAIL mid_reset_flags: got ovr=%b lock=%b want 0/0", overrun, locked); end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++)  send_bit(LL, 1'b1);
        for (int i = 0; i < 16; i++) send_bit(RL, 1'b1);
        send_frame(16'h1111, 16'h2222, 16, 16);
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_early_valid: got %b want 0", out_valid); end
        flush(1'b0, 1'b0, lat);
        vectors++; if (lat !== 4) begin errors++; $display("FAIL mid_latency: got %0d want 4", lat); end
        vectors++; if (out_l !== 16'h1111 || out_r !== 16'h2222) begin errors++; $display("FAIL mid_pair: got %h/%h want 1111/2222", out_l, out_r); end
        consume();
    endtask

`ifdef I2S_RX_LEFT_JUSTIFIED_EN
    task automatic test_left_justified();
        int lat;
        send_frame(16'h7FFF, 16'h8000, 16, 16);
        flush(1'b0, 1'b0, lat);
        vectors++; if (out_l !== 16'h7FFF) begin errors++; $display("FAIL lj_out_l: got %h want 7fff", out_l); end
        vectors++; if (out_r !== 16'h8000) begin errors++; $display("FAIL lj_out_r: got %h want 8000", out_r); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_short_word();
        test_overrun();
        test_ready_on_publish();
        test_enable();
        test_reset_midframe();
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
        test_left_justified();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
